// File: rtl/truth_table_scanner.sv
// Exhaustive sweep of a 4-input, 1-output function: drives a..d through 0000..1111,
// captures s per vector, and compares the observed truth table to EXPECTED.
module truth_table_scanner #(
    parameter logic [15:0] EXPECTED = 16'hAC3C,
    parameter int unsigned SETTLE   = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        s,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] table_out,
    output logic [4:0]  fail_count,
    output logic [3:0]  fail_idx
);

    typedef enum logic [1:0] {IDLE, APPLY, FINISH} state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_idx;
    logic [7:0]  r_wait_cnt;
    logic [15:0] r_table;
    logic [4:0]  r_fail_count;
    logic [3:0]  r_fail_idx;
    logic        r_pass;

    logic        w_sample;
    logic        w_mismatch;
    logic [4:0]  w_fail_count_nxt;

    assign w_sample         = (r_state == APPLY) && (r_wait_cnt == SETTLE_LAST);
    assign w_mismatch       = w_sample && (s != EXPECTED[r_idx]);
    // pass must see the mismatch from the final vector, so it uses the updated count
    assign w_fail_count_nxt = r_fail_count + {4'b0000, w_mismatch};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = APPLY;
            APPLY:   if (w_sample && (r_idx == 4'd15)) w_state_nxt = FINISH;
            FINISH:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_idx        <= '0;
            r_wait_cnt   <= '0;
            r_table      <= '0;
            r_fail_count <= '0;
            r_fail_idx   <= '0;
            r_pass       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_idx        <= '0;
                        r_wait_cnt   <= '0;
                        r_table      <= '0;
                        r_fail_count <= '0;
                        r_fail_idx   <= '0;
                        r_pass       <= 1'b0;
                    end
                end
                APPLY: begin
                    if (w_sample) begin
                        r_table[r_idx] <= s;
                        r_fail_count   <= w_fail_count_nxt;
                        if (w_mismatch && (r_fail_count == 5'd0)) r_fail_idx <= r_idx;
                        if (r_idx == 4'd15) begin
                            r_pass <= (w_fail_count_nxt == 5'd0);
                        end else begin
                            r_idx      <= r_idx + 4'd1;
                            r_wait_cnt <= '0;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign {a, b, c, d} = (r_state == APPLY) ? r_idx : 4'b0000;
    assign busy         = (r_state != IDLE);
    assign done         = (r_state == FINISH);
    assign pass         = r_pass;
    assign table_out    = r_table;
    assign fail_count   = r_fail_count;
    assign fail_idx     = r_fail_idx;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench for truth_table_scanner: SETTLE=1 and SETTLE=3 instances driven
// by a behavioural function-under-test whose fault mode is selectable.
module tb_truth_table_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       start1, start3;
    logic [1:0] fmode;
    logic       sel;

    logic a1, b1, c1, d1, s1, busy1, done1, pass1;
    logic a3, b3, c3, d3, s3, busy3, done3, pass3;
    logic [15:0] tbl1, tbl3;
    logic [4:0]  fc1, fc3;
    logic [3:0]  fi1, fi3;

    function automatic logic fut(input logic [1:0] m, input logic a, input logic b,
                                 input logic c, input logic d);
        case (m)
            2'd0:    return (~b & c) | (~a & b & ~c) | (a & b & d);
            2'd1:    return (~b & c) | (~a & b & ~c);
            default: return 1'b0;
        endcase
    endfunction

    assign s1 = fut(fmode, a1, b1, c1, d1);
    assign s3 = fut(fmode, a3, b3, c3, d3);

    truth_table_scanner #(.EXPECTED(16'hAC3C), .SETTLE(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .s(s1),
        .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .pass(pass1),
        .table_out(tbl1), .fail_count(fc1), .fail_idx(fi1)
    );

    truth_table_scanner #(.EXPECTED(16'hAC3C), .SETTLE(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .s(s3),
        .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3), .pass(pass3),
        .table_out(tbl3), .fail_count(fc3), .fail_idx(fi3)
    );

    logic [3:0]  m_abcd;
    logic        m_busy, m_done, m_pass;
    logic [15:0] m_tbl;
    logic [4:0]  m_fc;
    logic [3:0]  m_fi;
    assign m_abcd = sel ? {a3, b3, c3, d3} : {a1, b1, c1, d1};
    assign m_busy = sel ? busy3 : busy1;
    assign m_done = sel ? done3 : done1;
    assign m_pass = sel ? pass3 : pass1;
    assign m_tbl  = sel ? tbl3 : tbl1;
    assign m_fc   = sel ? fc3 : fc1;
    assign m_fi   = sel ? fi3 : fi1;

    int passed = 0;
    int total  = 0;
    logic [3:0] vq[$];

    task automatic set_start(input logic v);
        if (sel) start3 = v;
        else     start1 = v;
    endtask

    // Caller raises start at a negedge; the next posedge is E0.
    // smode: 0 = one-cycle pulse, 1 = start held high, 2 = pulse plus a stray start mid-scan
    task automatic run_scan(input string name, input int smode, input logic [15:0] et,
                            input logic [4:0] efc, input logic [3:0] efi, input logic ep);
        int unsigned st;
        logic [3:0] ev;
        st = sel ? 3 : 1;
        for (int k = 0; k < 16; k++)
            for (int unsigned r = 0; r < st; r++) vq.push_back(4'(k));
        @(posedge clk);
        for (int unsigned n = 0; n < 16 * st; n++) begin
            @(negedge clk);
            if (n == 0 && smode != 1) set_start(1'b0);
            if (smode == 2 && n == 4) set_start(1'b1);
            if (smode == 2 && n == 5) set_start(1'b0);
            ev = vq.pop_front();
            total++;
            if (m_abcd !== ev) $display("FAIL %s vector cyc%0d: got %h want %h", name, n, m_abcd, ev);
            else passed++;
            total++;
            if (m_busy !== 1'b1 || m_done !== 1'b0)
                $display("FAIL %s busy/done cyc%0d: got %b/%b want 1/0", name, n, m_busy, m_done);
            else passed++;
        end
        @(negedge clk);
        total++;
        if (m_done !== 1'b1 || m_busy !== 1'b1 || m_abcd !== 4'h0)
            $display("FAIL %s finish: done=%b busy=%b abcd=%h want 1 1 0", name, m_done, m_busy, m_abcd);
        else passed++;
        total++;
        if (m_tbl !== et) $display("FAIL %s table: got %h want %h", name, m_tbl, et);
        else passed++;
        total++;
        if (m_fc !== efc) $display("FAIL %s fail_count: got %0d want %0d", name, m_fc, efc);
        else passed++;
        total++;
        if (m_pass !== ep) $display("FAIL %s pass: got %b want %b", name, m_pass, ep);
        else passed++;
        if (efc != 5'd0) begin
            total++;
            if (m_fi !== efi) $display("FAIL %s fail_idx: got %0d want %0d", name, m_fi, efi);
            else passed++;
        end
        if (smode != 1) begin
            @(negedge clk);
            total++;
            if (m_busy !== 1'b0 || m_done !== 1'b0)
                $display("FAIL %s after finish busy/done: got %b/%b want 0/0", name, m_busy, m_done);
            else passed++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start1 = 1'b0; start3 = 1'b0; fmode = 2'd0; sel = 1'b0;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            sel = i[0];
            #1;
            total++;
            if ({m_abcd, m_busy, m_done, m_pass, m_tbl, m_fc, m_fi} !== 32'h0)
                $display("FAIL reset inst%0d: abcd=%h busy=%b done=%b pass=%b tbl=%h fc=%0d fi=%0d want all 0",
                         i, m_abcd, m_busy, m_done, m_pass, m_tbl, m_fc, m_fi);
            else passed++;
        end
        @(negedge clk);
        reset_n = 1'b1; sel = 1'b0;
    endtask

    task automatic test_functions();
        sel = 1'b0;
        fmode = 2'd0; @(negedge clk); set_start(1'b1);
        run_scan("correct", 0, 16'hAC3C, 5'd0, 4'd0, 1'b1);
        repeat (3) @(negedge clk);
        total++;
        if (m_tbl !== 16'hAC3C || m_pass !== 1'b1) $display("FAIL hold: tbl=%h pass=%b want AC3C 1", m_tbl, m_pass);
        else passed++;
        fmode = 2'd1; @(negedge clk); set_start(1'b1);
        run_scan("faulty", 0, 16'h0C3C, 5'd2, 4'd13, 1'b0);
        fmode = 2'd2; @(negedge clk); set_start(1'b1);
        run_scan("const0", 0, 16'h0000, 5'd8, 4'd2, 1'b0);
    endtask

    task automatic test_settle3();
        sel = 1'b1; fmode = 2'd0;
        @(negedge clk); set_start(1'b1);
        run_scan("settle3", 0, 16'hAC3C, 5'd0, 4'd0, 1'b1);
        sel = 1'b0;
    endtask

    task automatic test_reset_midscan();
        bit hit;
        sel = 1'b0; fmode = 2'd0;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (m_abcd == 4'd7) hit = 1'b1;
            else @(negedge clk);
        end
        total++;
        if (!hit) $display("FAIL midreset: vector 7 not reached, abcd=%h", m_abcd);
        else passed++;
        reset_n = 1'b0;
        @(negedge clk);
        total++;
        if ({m_abcd, m_busy, m_done, m_pass, m_tbl, m_fc, m_fi} !== 32'h0)
            $display("FAIL midreset values: abcd=%h busy=%b done=%b pass=%b tbl=%h fc=%0d fi=%0d want all 0",
                     m_abcd, m_busy, m_done, m_pass, m_tbl, m_fc, m_fi);
        else passed++;
        @(negedge clk); reset_n = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_done !== 1'b0 || m_busy !== 1'b0) hit = 1'b1;
        end
        total++;
        if (hit) $display("FAIL midreset no done: got activity after abort, want none");
        else passed++;
        @(negedge clk); start1 = 1'b1;
        run_scan("after_reset", 0, 16'hAC3C, 5'd0, 4'd0, 1'b1);
    endtask

    task automatic test_start_during_busy();
        sel = 1'b0; fmode = 2'd0;
        @(negedge clk); start1 = 1'b1;
        run_scan("busy_start", 2, 16'hAC3C, 5'd0, 4'd0, 1'b1);
    endtask

    task automatic test_back_to_back();
        bit got;
        sel = 1'b0; fmode = 2'd1;
        @(negedge clk); start1 = 1'b1;
        run_scan("b2b_first", 1, 16'h0C3C, 5'd2, 4'd13, 1'b0);
        @(negedge clk);
        total++;
        if (m_busy !== 1'b0 || m_done !== 1'b0 || m_abcd !== 4'h0)
            $display("FAIL b2b idle gap: busy=%b done=%b abcd=%h want 0 0 0", m_busy, m_done, m_abcd);
        else passed++;
        @(negedge clk);
        total++;
        if (m_busy !== 1'b1 || m_abcd !== 4'h0)
            $display("FAIL b2b restart: busy=%b abcd=%h want 1 0", m_busy, m_abcd);
        else passed++;
        start1 = 1'b0;
        fmode = 2'd0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (m_done === 1'b1) got = 1'b1;
        end
        total++;
        if (!got) $display("FAIL b2b second done: timeout waiting for done");
        else passed++;
        total++;
        if (m_tbl !== 16'hAC3C || m_pass !== 1'b1 || m_fc !== 5'd0)
            $display("FAIL b2b second result: tbl=%h pass=%b fc=%0d want AC3C 1 0", m_tbl, m_pass, m_fc);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_functions();
        test_settle3();
        test_reset_midscan();
        test_start_during_busy();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequential exhaustive tester for a 4-input, 1-output combinational function block. On a start request it drives the function's inputs a, b, c and d through all 16 combinations, from 0000 to 1111, and samples the function's output s for each one. It assembles the observed 16-bit truth table, compares it bit-by-bit against an expected table and reports pass/fail with a done pulse. It sits on the driving side of the function under test: it produces the inputs and consumes the output, replacing the simulation-only sweep with synthesizable hardware.

## Interface
- EXPECTED, 16'hAC3C, expected truth table; bit index = {a,b,c,d}. The default encodes s = (~b&c) | (~a&b&~c) | (a&b&d).
- SETTLE, 1, cycles each vector is held before s is sampled; legal range 1..255.

- clk  input  1  single clock; all state changes on rising edge
- reset_n  input  1  reset; **synchronous, active-low**
- start  input  1  scan request, sampled only in IDLE
- s  input  1  output of the function under test
- a  output  1  input vector bit 3 (MSB) to the function
- b  output  1  input vector bit 2
- c  output  1  input vector bit 1
- d  output  1  input vector bit 0 (LSB)
- busy  output  1  high from scan start through the FINISH cycle
- done  output  1  one-cycle pulse at scan end
- pass  output  1  1 when the last scan had zero mismatches
- table_out  output  16  observed truth table of the last scan
- fail_count  output  5  mismatch count of the last scan, 0..16
- fail_idx  output  4  index of the first mismatch; meaningful only when fail_count != 0

## Operation
- Registers: state, idx[3:0], wait_cnt[7:0], table_out, fail_count, fail_idx, pass. Outputs {a,b,c,d} = idx while in APPLY, and 0000 otherwise.
- Reset values (reset_n = 0 at a rising edge):
  - state = IDLE
  - idx = 0, wait_cnt = 0
  - a = b = c = d = 0
  - busy = 0, done = 0, pass = 0
  - table_out = 16'h0000
  - fail_count = 0, fail_idx = 0
- IDLE → APPLY when start = 1:
  - idx ← 0, wait_cnt ← 0
  - table_out ← 0, fail_count ← 0, fail_idx ← 0, pass ← 0
- APPLY, while wait_cnt < SETTLE-1: wait_cnt ← wait_cnt+1.
- APPLY, when wait_cnt == SETTLE-1 (this edge is the sample edge for idx):
  - table_out[idx] ← s.
  - If s != EXPECTED[idx]: fail_count ← fail_count+1.
  - If s != EXPECTED[idx] and fail_count == 0 (first mismatch): fail_idx ← idx.
  - If idx == 15 → FINISH; otherwise idx ← idx+1, wait_cnt ← 0.
  - idx never wraps inside a scan.
- FINISH:
  - done = 1 and busy = 1 for exactly this cycle.
  - pass = (fail_count == 0), registered on the FINISH entry edge.
  - Next edge → IDLE.
- table_out, fail_count, fail_idx and pass hold after a scan until the next accepted start or reset.
- start is ignored in APPLY and FINISH.
- start held high continuously: a new scan is accepted on the first IDLE edge, i.e. back-to-back scans separated by one IDLE cycle.
- fail_count is 5 bits so an all-wrong scan reports 16 without overflow.

## Timing
- start sampled high at edge E0 → vector 0000 drives a..d during the cycle after E0; busy is high from the same cycle.
- Vector k, for k = 0..15, is held for SETTLE cycles and sampled at edge E0 + SETTLE·(k+1).
- FINISH occupies the cycle after edge E0 + 16·SETTLE:
  - done and pass are valid in that cycle.
  - busy falls and a..d return to 0000 after edge E0 + 16·SETTLE + 1.
- Total busy time is 16·SETTLE + 1 cycles.
- s must be stable by each sample edge; the block adds no synchronizer because the function under test is synchronous to clk.
- A reset asserted mid-scan aborts the scan at the next edge:
  - all reset values apply, including table_out = 0.
  - No done pulse is produced.
- done and busy are registered (state-decoded from registered state); no combinational path from start or s to any output.

## Test plan
- **Correct function, SETTLE = 1:**
  - start pulse at E0 → a..d step through 0000..1111 one per cycle.
  - done at cycle E0 + 17; table_out = 16'hAC3C, pass = 1, fail_count = 0.
- **Faulty function, term a&b&d missing:**
  - Response: table_out = 16'h0C3C.
  - pass = 0, fail_count = 2, fail_idx = 13.
- **Constant-0 function:**
  - Response: table_out = 0, fail_count = 8.
  - fail_idx = 2, pass = 0.
- **SETTLE = 3:**
  - Each vector is held 3 cycles.
  - done occurs 49 cycles after the start edge; busy is high for 49 cycles.
- **Reset mid-scan:**
  - reset_n low at idx = 7 → next cycle all outputs at reset values, no done pulse.
  - A following start produces a full clean scan.
- **start during busy, then start held high:**
  - start during busy is ignored; the scan length is unchanged.
  - start held high gives exactly one IDLE cycle between the done pulse and the next vector 0000.
